// File: rtl/simd_rpn_eval.sv
// simd_rpn_eval: SIMD reverse-polish evaluator. One accepted job carries a
// program of PROG_LEN 5-bit slots and four operand vectors x0..x3. Every
// lane runs the same program on its own operand stack. The final top of
// stack, a per-lane divide-by-zero flag and a shared error code are returned.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready job handshake (in_ready is high only in IDLE)
//   prog              program, slot k at [5k+4:5k] = {src[1:0], opcode[2:0]}
//   opnd              operand vectors, xs lane i at [(s*LANES+i)*WIDTH +: WIDTH]
//   sat_en            saturating arithmetic select
//   out_valid/out_ready result handshake
//   result, dz, err   per-lane value, per-lane div-by-zero, {imbalance, underflow, overflow}
module simd_rpn_eval #(
    parameter int LANES    = 8,
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 4,
    parameter int PROG_LEN = 16,
    parameter int EXP_MAX  = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PROG_LEN*5-1:0]    prog,
    input  logic [4*LANES*WIDTH-1:0] opnd,
    input  logic                     sat_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*WIDTH-1:0]   result,
    output logic [LANES-1:0]         dz,
    output logic [2:0]               err
);
    localparam int PC_W  = (PROG_LEN > 1) ? $clog2(PROG_LEN) : 1;
    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int CNT_W = (EXP_MAX > 1) ? $clog2(EXP_MAX) : 1;

    localparam logic [2:0] OP_END  = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_MUL  = 3'd4;
    localparam logic [2:0] OP_DIV  = 3'd5;
    localparam logic [2:0] OP_POW  = 3'd6;

    typedef enum logic [1:0] {IDLE, EXEC, POW, DONE} state_t;

    state_t                   state;
    logic [PROG_LEN*5-1:0]    prog_q;
    logic [4*LANES*WIDTH-1:0] opnd_q;
    logic                     sat_q;
    logic [PC_W-1:0]          pc;
    logic [SP_W-1:0]          sp;
    logic [CNT_W-1:0]         pow_cnt;
    logic [WIDTH-1:0]         stack   [LANES][DEPTH];
    logic [WIDTH-1:0]         pow_acc [LANES];

    logic [2:0]       cur_op, nxt_op;
    logic [1:0]       cur_src;
    logic [WIDTH-1:0] lhs [LANES], rhs [LANES], push_val [LANES];
    logic [WIDTH-1:0] alu_res [LANES], pow_next [LANES], top_after [LANES];
    logic [LANES-1:0] dz_hit;
    logic             retire, finish, is_end, fault_ovf, fault_unf, wr_en;
    logic [SP_W-1:0]  sp_after, wr_idx;

    function automatic logic [WIDTH-1:0] add_op(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic sat);
        logic [WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (sat && s[WIDTH]) return '1;
        return s[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] sub_op(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic sat);
        if (sat && (a < b)) return '0;
        return a - b;
    endfunction

    function automatic logic [WIDTH-1:0] mul_op(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic sat);
        logic [2*WIDTH-1:0] p;
        p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        if (sat && (|p[2*WIDTH-1:WIDTH])) return '1;
        return p[WIDTH-1:0];
    endfunction

    assign in_ready = (state == IDLE);

    // Fetch the current slot and peek at the following one. The peek lets a
    // POW be entered directly in state POW, so a POW costs exactly EXP_MAX
    // cycles with no separate decode cycle.
    always_comb begin
        cur_op  = OP_END;
        cur_src = '0;
        nxt_op  = OP_END;
        for (int k = 0; k < PROG_LEN; k++) begin
            if (int'(pc) == k) begin
                cur_op  = prog_q[5*k +: 3];
                cur_src = prog_q[5*k+3 +: 2];
            end
            if (int'(pc) + 1 == k) nxt_op = prog_q[5*k +: 3];
        end
    end

    // Per-lane operand selection and arithmetic. L is next-to-top, R is top.
    // The POW step multiplies only while the cycle index is below R, which
    // also clamps the exponent at EXP_MAX since the index never reaches it.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lhs[i]      = '0;
            rhs[i]      = '0;
            push_val[i] = '0;
            dz_hit[i]   = 1'b0;
            for (int d = 0; d < DEPTH; d++) begin
                if (int'(sp) == d + 2) lhs[i] = stack[i][d];
                if (int'(sp) == d + 1) rhs[i] = stack[i][d];
            end
            for (int s = 0; s < 4; s++) begin
                if (int'(cur_src) == s) push_val[i] = opnd_q[(s*LANES+i)*WIDTH +: WIDTH];
            end
            case (cur_op)
                OP_ADD:  alu_res[i] = add_op(lhs[i], rhs[i], sat_q);
                OP_SUB:  alu_res[i] = sub_op(lhs[i], rhs[i], sat_q);
                OP_MUL:  alu_res[i] = mul_op(lhs[i], rhs[i], sat_q);
                OP_DIV: begin
                    dz_hit[i]  = (rhs[i] == '0);
                    alu_res[i] = (rhs[i] == '0) ? '1 : lhs[i] / rhs[i];
                end
                default: alu_res[i] = rhs[i];
            endcase
            pow_next[i] = (WIDTH'(pow_cnt) < rhs[i]) ? mul_op(pow_acc[i], lhs[i], sat_q)
                                                      : pow_acc[i];
        end
    end

    // Instruction outcome: faults, stack write, new stack pointer and the
    // top-of-stack value as it will be after this instruction retires.
    always_comb begin
        retire    = 1'b0;
        is_end    = 1'b0;
        fault_ovf = 1'b0;
        fault_unf = 1'b0;
        wr_en     = 1'b0;
        wr_idx    = sp;
        sp_after  = sp;
        for (int i = 0; i < LANES; i++) top_after[i] = rhs[i];
        if (state == EXEC) begin
            case (cur_op)
                OP_END: is_end = 1'b1;
                OP_PUSH: begin
                    if (sp == SP_W'(DEPTH)) fault_ovf = 1'b1;
                    else begin
                        retire   = 1'b1;
                        wr_en    = 1'b1;
                        sp_after = sp + 1'b1;
                        for (int i = 0; i < LANES; i++) top_after[i] = push_val[i];
                    end
                end
                OP_ADD, OP_SUB, OP_MUL, OP_DIV: begin
                    if (sp < SP_W'(2)) fault_unf = 1'b1;
                    else begin
                        retire   = 1'b1;
                        wr_en    = 1'b1;
                        wr_idx   = sp - SP_W'(2);
                        sp_after = sp - 1'b1;
                        for (int i = 0; i < LANES; i++) top_after[i] = alu_res[i];
                    end
                end
                default: retire = 1'b1;
            endcase
        end else if (state == POW) begin
            if (sp < SP_W'(2)) fault_unf = 1'b1;
            else if (pow_cnt == CNT_W'(EXP_MAX - 1)) begin
                retire   = 1'b1;
                wr_en    = 1'b1;
                wr_idx   = sp - SP_W'(2);
                sp_after = sp - 1'b1;
                for (int i = 0; i < LANES; i++) top_after[i] = pow_next[i];
            end
        end
        finish = is_end || (retire && (int'(pc) == PROG_LEN - 1));
    end

    // Main FSM. Faults and program completion both land in DONE, which holds
    // the registered outputs until the consumer takes them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            dz        <= '0;
            err       <= '0;
            pc        <= '0;
            sp        <= '0;
            pow_cnt   <= '0;
            prog_q    <= '0;
            opnd_q    <= '0;
            sat_q     <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                pow_acc[i] <= '0;
                for (int d = 0; d < DEPTH; d++) stack[i][d] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        prog_q  <= prog;
                        opnd_q  <= opnd;
                        sat_q   <= sat_en;
                        pc      <= '0;
                        sp      <= '0;
                        dz      <= '0;
                        err     <= '0;
                        result  <= '0;
                        pow_cnt <= '0;
                        for (int i = 0; i < LANES; i++) pow_acc[i] <= WIDTH'(1);
                        state   <= (prog[2:0] == OP_POW) ? POW : EXEC;
                    end
                end
                EXEC, POW: begin
                    if (fault_ovf || fault_unf) begin
                        err       <= {1'b0, fault_unf, fault_ovf};
                        result    <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        if (state == POW) begin
                            pow_cnt <= pow_cnt + 1'b1;
                            for (int i = 0; i < LANES; i++) pow_acc[i] <= pow_next[i];
                        end
                        if (state == EXEC && retire) dz <= dz | dz_hit;
                        for (int i = 0; i < LANES; i++)
                            for (int d = 0; d < DEPTH; d++)
                                if (wr_en && int'(wr_idx) == d) stack[i][d] <= top_after[i];
                        sp <= sp_after;
                        if (finish) begin
                            out_valid <= 1'b1;
                            state     <= DONE;
                            if (sp_after == SP_W'(1)) begin
                                for (int i = 0; i < LANES; i++) result[i*WIDTH +: WIDTH] <= top_after[i];
                            end else begin
                                err[2] <= 1'b1;
                                result <= '0;
                            end
                        end else if (retire) begin
                            pc      <= pc + 1'b1;
                            pow_cnt <= '0;
                            for (int i = 0; i < LANES; i++) pow_acc[i] <= WIDTH'(1);
                            state   <= (nxt_op == OP_POW) ? POW : EXEC;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_simd_rpn_eval.sv
// tb_simd_rpn_eval: self-checking bench for simd_rpn_eval with LANES=4,
// WIDTH=16, DEPTH=4, PROG_LEN=16, EXP_MAX=15. Directed jobs cover the worked
// examples, saturation, faults, back-pressure and mid-POW reset; random jobs
// are compared against a queue-based reference evaluator.
module tb_simd_rpn_eval;
    localparam logic [2:0] OP_END  = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_MUL  = 3'd4;
    localparam logic [2:0] OP_DIV  = 3'd5;
    localparam logic [2:0] OP_POW  = 3'd6;
    localparam logic [2:0] OP_NOP  = 3'd7;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [79:0]  prog;
    logic [255:0] opnd;
    logic         sat_en;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  result;
    logic [3:0]   dz;
    logic [2:0]   err;

    int n_checks;
    int n_pass;

    logic [79:0]  pg;
    int           pn;
    logic [63:0]  got;

    simd_rpn_eval #(
        .LANES(4), .WIDTH(16), .DEPTH(4), .PROG_LEN(16), .EXP_MAX(15)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .prog(prog), .opnd(opnd), .sat_en(sat_en), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .dz(dz), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something wedges outside a bounded wait.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        n_checks++;
        if (got_v === exp_v) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got_v, exp_v);
    endtask

    // Reference evaluator: each lane runs the program on a queue used as a
    // stack, with plain integer arithmetic and explicit clamp/wrap rules.
    task automatic runModel(input logic [79:0] p, input logic [255:0] x, input logic sat,
                            output logic [63:0] res, output logic [3:0] dzm,
                            output logic [2:0] errm, output int cyc);
        longint unsigned st[$];
        longint unsigned l, r, v;
        logic [2:0] op;
        logic [1:0] src;
        int e;
        bit stop;
        res = '0;
        dzm = '0;
        errm = '0;
        cyc = 0;
        for (int ln = 0; ln < 4; ln++) begin
            st.delete();
            stop = 0;
            cyc = 0;
            errm = '0;
            for (int k = 0; k < 16 && !stop; k++) begin
                op  = p[5*k +: 3];
                src = p[5*k+3 +: 2];
                cyc += (op == OP_POW) ? 15 : 1;
                if (op == OP_END) stop = 1;
                else if (op == OP_NOP) v = 0;
                else if (op == OP_PUSH) begin
                    if (st.size() == 4) begin errm[0] = 1'b1; stop = 1; end
                    else st.push_back(longint'(x[(int'(src)*4+ln)*16 +: 16]));
                end else if (st.size() < 2) begin
                    errm[1] = 1'b1;
                    stop = 1;
                end else begin
                    r = st.pop_back();
                    l = st.pop_back();
                    case (op)
                        OP_ADD: begin
                            v = l + r;
                            if (v > 65535) v = sat ? 65535 : v - 65536;
                        end
                        OP_SUB: begin
                            if (l < r) v = sat ? 0 : l + 65536 - r;
                            else v = l - r;
                        end
                        OP_MUL: begin
                            v = l * r;
                            if (v > 65535) v = sat ? 65535 : v % 65536;
                        end
                        OP_DIV: begin
                            if (r == 0) begin v = 65535; dzm[ln] = 1'b1; end
                            else v = l / r;
                        end
                        default: begin
                            e = (r > 15) ? 15 : int'(r);
                            v = 1;
                            for (int j = 0; j < e; j++) begin
                                if (sat) begin
                                    v = v * l;
                                    if (v > 65535) v = 65535;
                                end else v = (v * l) % 65536;
                            end
                        end
                    endcase
                    st.push_back(v);
                end
            end
            if (errm == 3'b000) begin
                if (st.size() != 1) errm[2] = 1'b1;
                else res[ln*16 +: 16] = st[0][15:0];
            end
        end
    endtask

    task automatic progClear();
        pg = '0;
        pn = 0;
    endtask

    task automatic emit(input logic [2:0] op, input logic [1:0] src);
        pg[5*pn +: 5] = {src, op};
        pn++;
    endtask

    function automatic logic [255:0] splat(input logic [15:0] v0, input logic [15:0] v1,
                                           input logic [15:0] v2, input logic [15:0] v3);
        logic [255:0] x;
        logic [15:0] v[4];
        v = '{v0, v1, v2, v3};
        for (int s = 0; s < 4; s++)
            for (int ln = 0; ln < 4; ln++) x[(s*4+ln)*16 +: 16] = v[s];
        return x;
    endfunction

    // Offers one job while idle; the accept happens on the next rising edge.
    task automatic applyStimulus(input logic [79:0] p, input logic [255:0] x, input logic sat);
        checkOutput("accept in_ready", 64'(in_ready), 64'd1);
        prog = p;
        opnd = x;
        sat_en = sat;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic runJob(input string tag, input logic [79:0] p, input logic [255:0] x,
                          input logic sat, input bit hold_test, output logic [63:0] got_res);
        logic [63:0] e_res;
        logic [3:0]  e_dz;
        logic [2:0]  e_err;
        int          e_cyc;
        int          cyc;
        runModel(p, x, sat, e_res, e_dz, e_err, e_cyc);
        applyStimulus(p, x, sat);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 1000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput({tag, " out_valid"}, 64'(out_valid), 64'd1);
        checkOutput({tag, " result"}, result, e_res);
        checkOutput({tag, " dz"}, 64'(dz), 64'(e_dz));
        checkOutput({tag, " err"}, 64'(err), 64'(e_err));
        if (e_err == 3'b000) checkOutput({tag, " latency"}, 64'(cyc), 64'(e_cyc));
        got_res = result;
        if (hold_test) begin
            in_valid = 1'b1;
            out_ready = 1'b0;
            for (int j = 0; j < 10; j++) begin
                @(posedge clk);
                #1;
                checkOutput({tag, " hold result"}, result, e_res);
                checkOutput({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
                checkOutput({tag, " hold out_valid"}, 64'(out_valid), 64'd1);
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            out_ready = 1'b0;
            checkOutput({tag, " release in_ready"}, 64'(in_ready), 64'd1);
            checkOutput({tag, " release out_valid"}, 64'(out_valid), 64'd0);
            @(posedge clk);
            #1;
            checkOutput({tag, " no stray accept"}, 64'(in_ready), 64'd1);
            checkOutput({tag, " idle result"}, result, e_res);
        end else begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            checkOutput({tag, " release"}, 64'(in_ready), 64'd1);
        end
    endtask

    task automatic makeRandom(output logic [79:0] p, output logic [255:0] x, output logic sat);
        int d, r;
        logic [2:0] op;
        logic [1:0] src;
        p = '0;
        d = 0;
        for (int k = 0; k < 16; k++) begin
            r = $urandom_range(0, 99);
            src = 2'($urandom_range(0, 3));
            if (r < 6) op = 3'($urandom_range(0, 7));
            else if (d == 1 && r >= 85) op = OP_END;
            else if (d < 2) op = OP_PUSH;
            else if (d >= 4) op = 3'($urandom_range(2, 6));
            else if (r < 45) op = OP_PUSH;
            else if (r < 50) op = OP_NOP;
            else op = 3'($urandom_range(2, 6));
            p[5*k +: 5] = {src, op};
            if (op == OP_END) break;
            if (op == OP_PUSH) d++;
            else if (op >= OP_ADD && op <= OP_POW) d--;
            if (d < 0) d = 0;
        end
        for (int w = 0; w < 16; w++)
            x[w*16 +: 16] = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'($urandom_range(0, 7));
        sat = 1'($urandom_range(0, 1));
    endtask

    task automatic buildMainProg();
        progClear();
        emit(OP_PUSH, 0); emit(OP_PUSH, 1); emit(OP_ADD, 0); emit(OP_PUSH, 2);
        emit(OP_MUL, 0);  emit(OP_PUSH, 3); emit(OP_PUSH, 3); emit(OP_POW, 0);
        emit(OP_DIV, 0);  emit(OP_END, 0);
    endtask

    initial begin
        logic [255:0] x;
        logic [79:0]  rp;
        logic         rs;
        n_checks = 0;
        n_pass = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        prog = '0;
        opnd = '0;
        sat_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        $display("[TB] reset released");
        checkOutput("reset in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset result", result, 64'd0);
        checkOutput("reset dz", 64'(dz), 64'd0);
        checkOutput("reset err", 64'(err), 64'd0);

        // Worked example: ((3+5)*4) / (2^2) = 8 in 24 cycles.
        buildMainProg();
        runJob("main", pg, splat(16'd3, 16'd5, 16'd4, 16'd2), 1'b0, 1'b0, got);
        checkOutput("main value", got, 64'h0008_0008_0008_0008);

        // 0^0 is 1, so lane 0 divides by one instead of faulting.
        x = splat(16'd3, 16'd5, 16'd4, 16'd2);
        x[(3*4+0)*16 +: 16] = 16'd0;
        runJob("zero pow zero", pg, x, 1'b0, 1'b0, got);
        checkOutput("zero pow zero value", got, 64'h0008_0008_0008_0020);

        // 0^2 = 0 divisor on lane 1 only.
        progClear();
        emit(OP_PUSH, 1); emit(OP_PUSH, 0); emit(OP_PUSH, 2); emit(OP_POW, 0);
        emit(OP_DIV, 0);  emit(OP_END, 0);
        x = splat(16'd3, 16'd100, 16'd2, 16'd0);
        x[(0*4+1)*16 +: 16] = 16'd0;
        runJob("div zero", pg, x, 1'b0, 1'b0, got);
        checkOutput("div zero value", got, 64'h000B_000B_FFFF_000B);
        checkOutput("div zero flag", 64'(dz), 64'h2);

        // Saturating and wrapping add/sub.
        progClear();
        emit(OP_PUSH, 0); emit(OP_PUSH, 1); emit(OP_ADD, 0); emit(OP_END, 0);
        x = splat(16'hFFF0, 16'h0020, 16'd0, 16'd0);
        runJob("add sat", pg, x, 1'b1, 1'b0, got);
        checkOutput("add sat value", got, 64'hFFFF_FFFF_FFFF_FFFF);
        runJob("add wrap", pg, x, 1'b0, 1'b0, got);
        checkOutput("add wrap value", got, 64'h0010_0010_0010_0010);
        progClear();
        emit(OP_PUSH, 0); emit(OP_PUSH, 1); emit(OP_SUB, 0); emit(OP_END, 0);
        x = splat(16'd3, 16'd5, 16'd0, 16'd0);
        runJob("sub sat", pg, x, 1'b1, 1'b0, got);
        checkOutput("sub sat value", got, 64'h0);
        runJob("sub wrap", pg, x, 1'b0, 1'b0, got);
        checkOutput("sub wrap value", got, 64'hFFFE_FFFE_FFFE_FFFE);

        // Structural faults.
        progClear();
        repeat (5) emit(OP_PUSH, 0);
        runJob("overflow", pg, x, 1'b0, 1'b0, got);
        checkOutput("overflow err", 64'(err), 64'b001);
        progClear();
        emit(OP_ADD, 0);
        runJob("underflow", pg, x, 1'b0, 1'b0, got);
        checkOutput("underflow err", 64'(err), 64'b010);
        progClear();
        emit(OP_PUSH, 0); emit(OP_PUSH, 1); emit(OP_END, 0);
        runJob("imbalance", pg, x, 1'b0, 1'b0, got);
        checkOutput("imbalance err", 64'(err), 64'b100);

        // Back-pressure in DONE with a competing job offered.
        buildMainProg();
        runJob("hold", pg, splat(16'd3, 16'd5, 16'd4, 16'd2), 1'b0, 1'b1, got);

        // Reset during the seventh POW cycle, then a clean job.
        applyStimulus(pg, splat(16'd3, 16'd5, 16'd4, 16'd2), 1'b0);
        repeat (13) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midpow out_valid", 64'(out_valid), 64'd0);
        checkOutput("midpow result", result, 64'd0);
        checkOutput("midpow in_ready", 64'(in_ready), 64'd1);
        checkOutput("midpow err", 64'(err), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post reset in_ready", 64'(in_ready), 64'd1);
        runJob("after reset", pg, splat(16'd3, 16'd5, 16'd4, 16'd2), 1'b0, 1'b0, got);
        checkOutput("after reset value", got, 64'h0008_0008_0008_0008);

        // Random programs against the reference evaluator.
        for (int n = 0; n < 40; n++) begin
            makeRandom(rp, x, rs);
            runJob($sformatf("rnd%0d", n), rp, x, rs, 1'b0, got);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
